add_result_buffer: RTL and testbench
====================================

ADD_RESULT_BUFFER -- requirements
Module: add_result_buffer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; parameter DEPTH, default 4, number of result entries, power of two, range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  adder stage presents a result this cycle.
REQ-005 in_ready  output  1  buffer can accept a result this cycle.
REQ-006 sum  input  32  adder sum.
REQ-007 carryout  input  1  adder carry-out.
REQ-008 overflow  input  1  adder signed overflow.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  consumer takes head entry this cycle.
REQ-011 out_data  output  32  head entry sum.
REQ-012 out_flags  output  4  head entry flags {N,Z,C,V}, bit 3 = N.
REQ-013 count  output  clog2(DEPTH)+1  number of stored entries.
REQ-014 ovf_count  output  8  number of accepted results with V=1.
REQ-015 clr_sticky  input  1  clears sticky_ovf.
REQ-016 sticky_ovf  output  1  sticky overflow indicator (see Configuration).

Function
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count < DEPTH), registered-state only; a pop in the same cycle SHALL NOT raise in_ready when full.
REQ-019 out_valid SHALL equal (count != 0); out_data and out_flags SHALL be 0 when out_valid=0.
REQ-020 Flags SHALL be computed at push: N=sum[31], Z=(sum==0), C=carryout, V=overflow; stored with the sum.
REQ-021 Latency: a push into an empty buffer SHALL make out_valid=1 with that entry on out_data in the following cycle; no same-cycle bypass.
REQ-022 Entries SHALL be delivered in push order; read/write pointers SHALL wrap modulo DEPTH.
REQ-023 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and move both pointers.
REQ-024 Push only SHALL increment count; pop only SHALL decrement count; in_valid while full and out_ready while empty SHALL have no effect.
REQ-025 ovf_count SHALL increment on each push with overflow=1 and saturate at 255.
REQ-026 Occupancy states: EMPTY (count=0), PARTIAL, FULL (count=DEPTH); transitions only via REQ-023/024, never skipping a state.

Reset
REQ-027 On rst=1 at a clock edge: count=0, pointers=0, ovf_count=0, sticky_ovf=0, in_ready=1, out_valid=0, out_data=0, out_flags=0.
REQ-028 Reset SHALL take priority over concurrent push, pop and clr_sticky; entries in flight SHALL be discarded; storage array contents need not be cleared.

Configuration
REQ-029 Macro ADD_RESULT_STICKY_OVF_EN: when defined, sticky_ovf SHALL set on any push with overflow=1, clear on clr_sticky=1, and set SHALL win when both occur in the same cycle.
REQ-030 When ADD_RESULT_STICKY_OVF_EN is undefined, sticky_ovf SHALL be constant 0, clr_sticky SHALL be ignored, and no sticky register SHALL be synthesised.

Verification
REQ-031 Reset then push sum=0x1B1B1B1A, carryout=0, overflow=0 -> next cycle out_valid=1, out_data=0x1B1B1B1A, out_flags=0000, count=1.
REQ-032 Push 0x00000000 with carryout=1, then 0x80000000 with overflow=1, out_ready=1 -> out_flags 0110 then 1001 in order; ovf_count=1.
REQ-033 DEPTH=4, out_ready=0, push 5 values -> in_ready=0 after 4th, 5th ignored, count=4; then pop all -> 4 values in order, count=0.
REQ-034 count=2, in_valid=1 and out_ready=1 for 6 cycles -> count stays 2, pointers wrap, output order preserved.
REQ-035 Macro defined: push with overflow=1 and clr_sticky=1 same cycle -> sticky_ovf=1; clr_sticky alone next cycle -> 0; undefined -> always 0.
REQ-036 rst asserted with count=3 and push pending -> next cycle count=0, out_valid=0, out_data=0, ovf_count=0.

Source files
------------

// File: rtl/add_result_buffer.sv
// -----------------------------------------------------------------------------
// add_result_buffer
//
// Small in-order FIFO that captures results from an adder stage together with
// the condition flags {N,Z,C,V} derived from each result at the moment it is
// accepted. Entries are delivered to the consumer in push order through a
// valid/ready handshake. An 8-bit saturating counter tracks how many accepted
// results carried signed overflow.
//
// Optional feature (macro ADD_RESULT_STICKY_OVF_EN):
//   defined   -> sticky_ovf sets on any accepted result with overflow=1 and
//                clears on clr_sticky; a set wins over a clear in the same
//                cycle.
//   undefined -> sticky_ovf is tied to 0, clr_sticky is ignored and no sticky
//                register exists.
//
// Parameters:
//   DEPTH      number of result entries; power of two in the range 2..16.
//
// Ports:
//   clk        sole clock, all state changes on its rising edge
//   rst        synchronous active-high reset
//   in_valid   adder presents a result this cycle
//   in_ready   buffer can accept a result (count < DEPTH, registered state)
//   sum        adder sum
//   carryout   adder carry-out
//   overflow   adder signed overflow
//   out_valid  head entry available (count != 0)
//   out_ready  consumer takes the head entry this cycle
//   out_data   head entry sum, 0 while out_valid=0
//   out_flags  head entry flags {N,Z,C,V}, 0 while out_valid=0
//   count      number of stored entries
//   ovf_count  saturating count of accepted results with overflow=1
//   clr_sticky clears sticky_ovf
//   sticky_ovf sticky overflow indicator
// -----------------------------------------------------------------------------
module add_result_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              sum,
  input  logic                     carryout,
  input  logic                     overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               ovf_count,
  input  logic                     clr_sticky,
  output logic                     sticky_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  // Occupancy states
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  // Flags packed as {N,Z,C,V} with N in bit 3
  function automatic logic [3:0] flags_of(input logic [31:0] s,
                                          input logic        c,
                                          input logic        v);
    flags_of = {s[31], (s == 32'd0), c, v};
  endfunction

  // Pointer advance with explicit wrap back to entry 0
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  logic [35:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    ovf_cnt_q, ovf_cnt_d;
  logic          push_s;
  logic          pop_s;

  // Handshake flags depend only on registered occupancy, so a pop while full
  // does not open the input in the same cycle.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // Next-state for pointers, occupancy count and overflow counter
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_cnt_d = ovf_cnt_q;
    case ({push_s, pop_s})
      2'b10: begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        count_d  = count_q + CW'(1);
      end
      2'b01: begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d  = count_q - CW'(1);
      end
      2'b11: begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      default: begin
        count_d = count_q;
      end
    endcase
    if (push_s && overflow && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Occupancy state follows the next count; a single push or pop moves it by
  // at most one step, so no state is ever skipped.
  always_comb begin
    if (count_d == '0) begin
      state_d = ST_EMPTY;
    end else if (count_d == DEPTH_C) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_PARTIAL;
    end
  end

  // Control registers; reset wins over any concurrent push or pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= ST_EMPTY;
      ovf_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Entry storage; contents are not cleared by reset, only the write is gated
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_q[wr_ptr_q] <= {flags_of(sum, carryout, overflow), sum};
    end
  end

  assign out_data  = out_valid ? mem_q[rd_ptr_q][31:0]  : 32'd0;
  assign out_flags = out_valid ? mem_q[rd_ptr_q][35:32] : 4'd0;
  assign count     = count_q;
  assign ovf_count = ovf_cnt_q;

`ifdef ADD_RESULT_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Sticky overflow: a set from an accepted overflow beats a clear request
  always_comb begin
    if (push_s && overflow) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Sticky overflow register
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_ovf = sticky_q;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_add_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_add_result_buffer
//
// Self-checking bench for add_result_buffer. The stimulus process keeps a
// behavioural model (occupancy as an integer, an expected-entry queue, an
// overflow tally and a sticky bit) and pushes every accepted result onto the
// scoreboard queue. A separate monitor pops and compares on each output
// handshake. Honours ADD_RESULT_STICKY_OVF_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_add_result_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   sum;
  logic          carryout;
  logic          overflow;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [3:0]    out_flags;
  logic [CW-1:0] count;
  logic [7:0]    ovf_count;
  logic          clr_sticky;
  logic          sticky_ovf;

  add_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum        (sum),
    .carryout   (carryout),
    .overflow   (overflow),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_flags  (out_flags),
    .count      (count),
    .ovf_count  (ovf_count),
    .clr_sticky (clr_sticky),
    .sticky_ovf (sticky_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state (reflects the DUT after the most recent edge)
  logic [35:0] exp_q[$];
  int          m_count  = 0;
  int          m_ovf    = 0;
  bit          m_sticky = 1'b0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Compare the registered-state outputs with the model
  task automatic check_state();
    chk("count", 36'(count), 36'(m_count));
    chk("in_ready", 36'(in_ready), 36'(m_count < DEPTH));
    chk("out_valid", 36'(out_valid), 36'(m_count != 0));
    chk("ovf_count", 36'(ovf_count), 36'(m_ovf));
    chk("sticky_ovf", 36'(sticky_ovf), 36'(m_sticky));
    if (m_count == 0) begin
      chk("idle_out_data", 36'(out_data), 36'd0);
      chk("idle_out_flags", 36'(out_flags), 36'd0);
    end
  endtask

  // One cycle: check the state left by the last edge, then apply new inputs
  // and advance the model to what the next edge should produce.
  task automatic step(input bit r, input bit iv, input logic [31:0] s,
                      input bit c, input bit o, input bit ordy, input bit clr);
    bit acc;
    bit pp;
    logic [3:0] fl;
    @(posedge clk);
    #1;
    check_state();
    rst        = r;
    in_valid   = iv;
    sum        = s;
    carryout   = c;
    overflow   = o;
    out_ready  = ordy;
    clr_sticky = clr;
    if (r) begin
      exp_q.delete();
      m_count  = 0;
      m_ovf    = 0;
      m_sticky = 1'b0;
    end else begin
      acc = iv && (m_count < DEPTH);
      pp  = ordy && (m_count > 0);
      if (acc) begin
        fl = {s[31], s == 32'd0, c, o};
        exp_q.push_back({fl, s});
        if (o && m_ovf < 255) m_ovf++;
      end
`ifdef ADD_RESULT_STICKY_OVF_EN
      if (acc && o) m_sticky = 1'b1;
      else if (clr) m_sticky = 1'b0;
`endif
      m_count = m_count + int'(acc) - int'(pp);
    end
  endtask

  // Monitor: compare the head entry on every cycle it is presented, pop on take
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 36'(out_valid), 36'd0);
        end else begin
          e = exp_q[0];
          chk("out_data", 36'(out_data), 36'(e[31:0]));
          chk("out_flags", 36'(out_flags), 36'(e[35:32]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sum = 32'd0; carryout = 1'b0;
    overflow = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;

    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single push into an empty buffer, visible the following cycle
    step(1'b0, 1'b1, 32'h1B1B1B1A, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Flag derivation: zero with carry, then negative with overflow
    step(1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();

    // Fill past capacity with the consumer stalled, then drain
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);
    idle(1'b0);

    // Hold two entries and stream through with simultaneous push/pop
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();

    // Sticky overflow: set beats clear in the same cycle, clear alone then clears
    step(1'b0, 1'b1, $urandom, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] s;
      s = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      step(1'b0, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0));
    end
    drain();

    // Drive the overflow counter into saturation
    for (int i = 0; i < 300; i++)
      step(1'b0, 1'b1, $urandom, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();

    // Reset with three entries held and a push pending
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, $urandom, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    step(1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
